// File: rtl/upbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | upbus_pkg : shared widths, error read data and FSM encoding for the  |
// |             upbus decoder.                                           |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package upbus_pkg;

  localparam int UPBUS_AW = 25;
  localparam int UPBUS_DW = 16;

  localparam logic [UPBUS_DW-1:0] RDD_UNMAPPED = 16'hBAD0;
  localparam logic [UPBUS_DW-1:0] RDD_TIMEOUT  = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } upbus_state_t;

endpackage
`default_nettype wire

// File: rtl/upbus_tout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | upbus_tout : clear/enable access timeout counter; expired holds once |
// |              the count reaches TOUT_MAX.                             |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module upbus_tout #(
  parameter int TOUT_W   = 8,
  parameter int TOUT_MAX = 255
) (
  input  logic sclk,
  input  logic rst_,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TOUT_W-1:0] r_cnt;

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == TOUT_W'(TOUT_MAX));

endmodule
`default_nettype wire

// File: rtl/upbus_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | upbus_dec : up_* bus address decoder / slave arbiter with read mux,  |
// |             level up_rdy and sticky error flags.                     |
// |             UPBUS_TIMEOUT_EN enables the slave timeout counter.      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module upbus_dec
  import upbus_pkg::*;
#(
  parameter int NSLV     = 4,
  parameter int SLV_AW   = 20,
  parameter int TOUT_W   = 8,
  parameter int TOUT_MAX = 255
) (
  input  logic                     sclk,
  input  logic                     rst_,
  input  logic [UPBUS_AW-1:0]      up_addr,
  input  logic                     up_cs,
  input  logic                     up_rds,
  input  logic                     up_wrs,
  input  logic [UPBUS_DW-1:0]      up_wrd,
  output logic [UPBUS_DW-1:0]      up_rdd,
  output logic                     up_rdy,
  output logic [NSLV-1:0]          slv_sel,
  output logic [SLV_AW-1:0]        slv_addr,
  output logic [NSLV-1:0]          slv_rds,
  output logic [NSLV-1:0]          slv_wrs,
  output logic [UPBUS_DW-1:0]      slv_wrd,
  input  logic [UPBUS_DW*NSLV-1:0] slv_rdd,
  input  logic [NSLV-1:0]          slv_rdy,
  input  logic                     err_clr,
  output logic                     err_dec,
  output logic                     err_tout
);

  localparam int IW = UPBUS_AW - SLV_AW;

  upbus_state_t          r_state;
  logic                  r_is_wr;
  logic [UPBUS_DW-1:0]   r_up_rdd;
  logic                  r_up_rdy;
  logic [NSLV-1:0]       r_slv_sel;
  logic [SLV_AW-1:0]     r_slv_addr;
  logic [NSLV-1:0]       r_slv_rds;
  logic [NSLV-1:0]       r_slv_wrs;
  logic [UPBUS_DW-1:0]   r_slv_wrd;
  logic                  r_err_dec;
  logic                  r_err_tout;

  logic [IW-1:0]         w_idx;
  logic                  w_mapped;
  logic [NSLV-1:0]       w_sel;
  logic                  w_rdy;
  logic [UPBUS_DW-1:0]   w_rdd;
  logic                  w_expired;

  assign w_idx    = up_addr[UPBUS_AW-1:SLV_AW];
  assign w_mapped = ({1'b0, w_idx} < (IW+1)'(NSLV));

  // The registered one-hot select doubles as the read/ready mux control.
  always_comb begin
    w_sel = '0;
    w_rdd = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_sel[i] = (w_idx == IW'(i));
      if (r_slv_sel[i]) begin
        w_rdd = w_rdd | slv_rdd[UPBUS_DW*i +: UPBUS_DW];
      end
    end
    w_rdy = |(slv_rdy & r_slv_sel);
  end

`ifdef UPBUS_TIMEOUT_EN
  upbus_tout #(
    .TOUT_W   (TOUT_W),
    .TOUT_MAX (TOUT_MAX)
  ) u_tout (
    .sclk    (sclk),
    .rst_    (rst_),
    .clr     (r_state != ST_ACC),
    .en      (r_state == ST_ACC),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= ST_IDLE;
      r_is_wr    <= 1'b0;
      r_up_rdd   <= '0;
      r_up_rdy   <= 1'b0;
      r_slv_sel  <= '0;
      r_slv_addr <= '0;
      r_slv_rds  <= '0;
      r_slv_wrs  <= '0;
      r_slv_wrd  <= '0;
      r_err_dec  <= 1'b0;
      r_err_tout <= 1'b0;
    end else begin
      r_slv_rds <= '0;
      r_slv_wrs <= '0;
      // Flag sets below come later in the block so they win over a clear.
      if (err_clr) begin
        r_err_dec  <= 1'b0;
        r_err_tout <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (up_rds || up_wrs) begin
            r_is_wr    <= up_wrs;
            r_slv_addr <= up_addr[SLV_AW-1:0];
            r_slv_wrd  <= up_wrd;
            if (w_mapped) begin
              r_state   <= ST_ACC;
              r_slv_sel <= w_sel;
              if (up_wrs) r_slv_wrs <= w_sel;
              else        r_slv_rds <= w_sel;
            end else begin
              r_state   <= ST_DONE;
              r_up_rdy  <= 1'b1;
              r_err_dec <= 1'b1;
              if (!up_wrs) r_up_rdd <= RDD_UNMAPPED;
            end
          end
        end
        ST_ACC: begin
          if (!up_cs) begin
            r_state   <= ST_IDLE;
            r_slv_sel <= '0;
          end else if (w_rdy) begin
            r_state  <= ST_DONE;
            r_up_rdy <= 1'b1;
            if (!r_is_wr) r_up_rdd <= w_rdd;
          end else if (w_expired) begin
            r_state    <= ST_DONE;
            r_up_rdy   <= 1'b1;
            r_err_tout <= 1'b1;
            if (!r_is_wr) r_up_rdd <= RDD_TIMEOUT;
          end
        end
        ST_DONE: begin
          if (!up_cs) begin
            r_state   <= ST_IDLE;
            r_up_rdy  <= 1'b0;
            r_slv_sel <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_up_rdy  <= 1'b0;
          r_slv_sel <= '0;
        end
      endcase
    end
  end

  assign up_rdd   = r_up_rdd;
  assign up_rdy   = r_up_rdy;
  assign slv_sel  = r_slv_sel;
  assign slv_addr = r_slv_addr;
  assign slv_rds  = r_slv_rds;
  assign slv_wrs  = r_slv_wrs;
  assign slv_wrd  = r_slv_wrd;
  assign err_dec  = r_err_dec;
  assign err_tout = r_err_tout;

endmodule
`default_nettype wire

// File: tb/tb_upbus_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_upbus_dec : vector table + scoreboard bench for upbus_dec.        |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_upbus_dec;
  import upbus_pkg::*;

  localparam int NSLV = 4;
  localparam int SLV_AW = 20;
  localparam int TOUT_W = 8;
  localparam int TOUT_MAX = 255;

  logic                sclk = 1'b0;
  logic                rst_ = 1'b0;
  logic [24:0]         up_addr = '0;
  logic                up_cs = 1'b0;
  logic                up_rds = 1'b0;
  logic                up_wrs = 1'b0;
  logic [15:0]         up_wrd = '0;
  logic [15:0]         up_rdd;
  logic                up_rdy;
  logic [NSLV-1:0]     slv_sel;
  logic [SLV_AW-1:0]   slv_addr;
  logic [NSLV-1:0]     slv_rds;
  logic [NSLV-1:0]     slv_wrs;
  logic [15:0]         slv_wrd;
  logic [16*NSLV-1:0]  slv_rdd;
  logic [NSLV-1:0]     slv_rdy;
  logic                err_clr = 1'b0;
  logic                err_dec;
  logic                err_tout;

  upbus_dec #(.NSLV(NSLV), .SLV_AW(SLV_AW), .TOUT_W(TOUT_W), .TOUT_MAX(TOUT_MAX)) dut (
    .sclk(sclk), .rst_(rst_), .up_addr(up_addr), .up_cs(up_cs), .up_rds(up_rds),
    .up_wrs(up_wrs), .up_wrd(up_wrd), .up_rdd(up_rdd), .up_rdy(up_rdy),
    .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_rds(slv_rds), .slv_wrs(slv_wrs),
    .slv_wrd(slv_wrd), .slv_rdd(slv_rdd), .slv_rdy(slv_rdy), .err_clr(err_clr),
    .err_dec(err_dec), .err_tout(err_tout)
  );

  always #5 sclk = ~sclk;

  // Slave model: fixed data per slave, ready level after rdy_dly select cycles.
  int rdy_dly = 1000;
  int acc_cyc;
  assign slv_rdd = {16'h3333, 16'h1234, 16'h2222, 16'h1111};
  always @(posedge sclk or negedge rst_) begin
    if (!rst_)             acc_cyc <= 0;
    else if (slv_sel == 0) acc_cyc <= 0;
    else                   acc_cyc <= acc_cyc + 1;
  end
  assign slv_rdy = (acc_cyc >= rdy_dly) ? slv_sel : '0;

  typedef struct {
    logic [24:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wrd;
    int          dly;
    int          lat;
    logic [15:0] rdd;
    logic [3:0]  sel;
    logic [3:0]  rds;
    logic [3:0]  wrs;
    logic        dec;
    logic        tout;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb[$];
  vec_t tbl[7];

  function automatic vec_t mk(logic [24:0] addr, logic rd, logic wr, logic [15:0] wrd,
                              int dly, int lat, logic [15:0] rdd, logic [3:0] sel,
                              logic [3:0] rds, logic [3:0] wrs, logic dec, logic tout);
    vec_t v;
    v.addr = addr; v.rd = rd; v.wr = wr; v.wrd = wrd; v.dly = dly; v.lat = lat;
    v.rdd = rdd; v.sel = sel; v.rds = rds; v.wrs = wrs; v.dec = dec; v.tout = tout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v);
    vec_t       e;
    int         lat;
    int         pulses;
    logic [3:0] sel1, rds_or, wrs_or;
    @(negedge sclk);
    up_addr = v.addr; up_wrd = v.wrd; up_cs = 1'b1;
    up_rds = v.rd; up_wrs = v.wr; rdy_dly = v.dly;
    sb.push_back(v);
    @(posedge sclk); #1;
    up_rds = 1'b0; up_wrs = 1'b0;
    lat = 1; sel1 = slv_sel; rds_or = '0; wrs_or = '0; pulses = 0;
    while (1) begin
      rds_or |= slv_rds;
      wrs_or |= slv_wrs;
      if ((slv_rds | slv_wrs) != 0) pulses++;
      if (up_rdy || lat >= 400) break;
      @(posedge sclk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("up_rdd", up_rdd, e.rdd);
    chk("slv_sel", sel1, e.sel);
    chk("slv_rds", rds_or, e.rds);
    chk("slv_wrs", wrs_or, e.wrs);
    chk("strobe_cycles", pulses, (e.sel != 0) ? 1 : 0);
    chk("err_dec", err_dec, e.dec);
    chk("err_tout", err_tout, e.tout);
    if (e.sel != 0) chk("slv_addr", slv_addr, e.addr[19:0]);
    if (e.wr && e.sel != 0) chk("slv_wrd", slv_wrd, e.wrd);
    @(posedge sclk); #1;
    chk("rdy_hold", up_rdy, 1'b1);
    chk("sel_hold", slv_sel, e.sel);
    @(negedge sclk); up_cs = 1'b0;
    @(posedge sclk); #1;
    chk("rdy_drop", up_rdy, 1'b0);
    chk("sel_clear", slv_sel, 4'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_rdy;
    tbl[0] = mk(25'h0200034, 1, 0, 16'h0000, 3, 5, 16'h1234, 4'b0100, 4'b0100, 4'b0000, 0, 0);
    tbl[1] = mk(25'h0000010, 0, 1, 16'hA5A5, 0, 2, 16'h1234, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    tbl[2] = mk(25'h01ABCDE, 1, 0, 16'h0000, 1, 3, 16'h2222, 4'b0010, 4'b0010, 4'b0000, 0, 0);
    tbl[3] = mk(25'h1F00000, 1, 0, 16'h0000, 0, 1, 16'hBAD0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    tbl[4] = mk(25'h0400000, 0, 1, 16'h7777, 0, 1, 16'hBAD0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    tbl[5] = mk(25'h0300002, 1, 0, 16'h0000, 0, 2, 16'h3333, 4'b1000, 4'b1000, 4'b0000, 1, 0);
    tbl[6] = mk(25'h0200000, 1, 1, 16'h5A5A, 2, 4, 16'h3333, 4'b0100, 4'b0000, 4'b0100, 1, 0);

    // Reset state
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_up_rdd", up_rdd, 16'h0);
    chk("rst_flags", {up_rdy, slv_rds, slv_wrs, err_dec, err_tout}, 0);
    chk("rst_sel_addr", {slv_sel, slv_addr}, 0);
    chk("rst_wrd", slv_wrd, 0);
    @(negedge sclk); rst_ = 1'b1;

    for (int i = 0; i < 7; i++) run_access(tbl[i]);

    // Sticky clear
    @(negedge sclk); err_clr = 1'b1;
    @(posedge sclk); #1; err_clr = 1'b0;
    chk("err_clr", err_dec, 1'b0);

    // Clear and unmapped set in the same cycle: set wins
    @(negedge sclk);
    up_addr = 25'h1F00000; up_cs = 1'b1; up_rds = 1'b1; err_clr = 1'b1;
    @(posedge sclk); #1; up_rds = 1'b0; err_clr = 1'b0;
    chk("set_wins", err_dec, 1'b1);
    chk("set_wins_rdy", up_rdy, 1'b1);
    @(negedge sclk); up_cs = 1'b0; err_clr = 1'b1;
    @(posedge sclk); #1; err_clr = 1'b0;
    chk("err_clr2", err_dec, 1'b0);

    // Host abort two cycles into ACC
    @(negedge sclk);
    up_addr = 25'h0100000; up_cs = 1'b1; up_rds = 1'b1; rdy_dly = 1000;
    @(posedge sclk); #1; up_rds = 1'b0;
    @(posedge sclk); #1;
    @(negedge sclk); up_cs = 1'b0;
    @(posedge sclk); #1;
    chk("abort_sel", slv_sel, 4'b0);
    seen_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      if (up_rdy) seen_rdy = 1;
      @(posedge sclk); #1;
    end
    chk("abort_no_rdy", seen_rdy, 0);
    chk("abort_rdd", up_rdd, 16'hBAD0);
    chk("abort_flags", {err_dec, err_tout}, 2'b00);
    run_access(mk(25'h0300100, 1, 0, 16'h0, 1, 3, 16'h3333, 4'b1000, 4'b1000, 4'b0000, 0, 0));

`ifdef UPBUS_TIMEOUT_EN
    run_access(mk(25'h0100000, 1, 0, 16'h0, 1000, TOUT_MAX + 2, 16'hDEAD, 4'b0010,
                  4'b0010, 4'b0000, 0, 1));
    @(negedge sclk); err_clr = 1'b1;
    @(posedge sclk); #1; err_clr = 1'b0;
    chk("tout_clr", err_tout, 1'b0);
`endif

    // Asynchronous reset while in ACC
    @(negedge sclk);
    up_addr = 25'h0200010; up_wrd = 16'hCAFE; up_cs = 1'b1; up_wrs = 1'b1; rdy_dly = 1000;
    @(posedge sclk); #1; up_wrs = 1'b0;
    chk("pre_rst_sel", slv_sel, 4'b0100);
    @(posedge sclk); #2;
    rst_ = 1'b0;
    #1;
    chk("arst_rdd", up_rdd, 16'h0);
    chk("arst_sel_addr", {slv_sel, slv_addr}, 0);
    chk("arst_misc", {up_rdy, slv_rds, slv_wrs, err_dec, err_tout}, 0);
    chk("arst_wrd", slv_wrd, 0);
    @(negedge sclk); up_cs = 1'b0; rst_ = 1'b1;
    run_access(mk(25'h0200034, 1, 0, 16'h0, 0, 2, 16'h1234, 4'b0100, 4'b0100, 4'b0000, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/upbus_dec.md
# upbus_dec

Microprocessor-bus address decoder and slave arbiter that sits directly downstream of the CPLD host interface. It consumes the internal `up_*` bus: 25-bit address, rd/wr level, cs, and single-cycle rds/wrs strobes. It routes each access to one of NSLV slave register windows, muxes read data back, and generates the level `up_rdy`. Unmapped addresses and non-responding slaves (optionally timed out) return fixed error data and set sticky error flags.

## Interface
Parameters:
- NSLV, 4, number of slave windows (1..32)
- SLV_AW, 20, address bits per slave window; window index = up_addr[24:SLV_AW]
- TOUT_W, 8, timeout counter width
- TOUT_MAX, 255, cycles in ACC before timeout

Ports:
- Clock and reset: one clock `sclk`; reset `rst_`, asynchronous, active-low.
- sclk  in  1  system clock
- rst_  in  1  async active-low reset
- up_addr  in  25  access address, stable while up_cs high
- up_cs  in  1  access in progress (level)
- up_rds  in  1  read start strobe, one cycle
- up_wrs  in  1  write start strobe, one cycle
- up_wrd  in  16  write data
- up_rdd  out  16  read data, registered
- up_rdy  out  1  access complete, level
- slv_sel  out  NSLV  one-hot window select, registered
- slv_addr  out  SLV_AW  latched offset within window
- slv_rds  out  NSLV  one-cycle read strobe to selected slave
- slv_wrs  out  NSLV  one-cycle write strobe to selected slave
- slv_wrd  out  16  latched write data
- slv_rdd  in  16*NSLV  slave read data, slave i at [16i+15:16i]
- slv_rdy  in  NSLV  slave done, level or pulse
- err_clr  in  1  clears sticky error flags
- err_dec  out  1  sticky: unmapped access occurred
- err_tout  out  1  sticky: slave timeout occurred

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE, on up_rds|up_wrs:
  - Latch idx = up_addr[24:SLV_AW], offset, up_wrd, and direction. If both strobes are high, the access is a write.
  - idx < NSLV: go to ACC. Next cycle assert slv_sel[idx] and one-cycle slv_rds/slv_wrs[idx].
  - idx >= NSLV: go to DONE. up_rdd <= 16'hBAD0 on reads (unchanged on writes); set err_dec. No slave strobes.
- ACC:
  - slv_rdy[idx] high: capture slv_rdd[idx] into up_rdd on reads; go to DONE.
  - Timeout counter reaches TOUT_MAX: up_rdd <= 16'hDEAD on reads; set err_tout; go to DONE.
- DONE: up_rdy = 1. Hold until up_cs falls, then return to IDLE. slv_sel stays asserted through DONE and clears in IDLE.
- up_cs falls in ACC (host abort): return to IDLE next cycle. up_rdy is not asserted, flags and up_rdd are unchanged, and slv_sel clears.
- Strobes outside IDLE are ignored.
- up_rdd holds its value until the next read completes.
- err_clr and an error set in the same cycle: set wins.
- Reset mid-access: all outputs 0, FSM to IDLE, counter 0.

## Timing
- Reset values: up_rdd=0, up_rdy=0, slv_sel=0, slv_addr=0, slv_rds=0, slv_wrs=0, slv_wrd=0, err_dec=0, err_tout=0.
- Strobe in cycle T: slv_sel and slv_rds/wrs in T+1.
- slv_rdy seen in T+1+k: up_rdd and up_rdy valid in T+2+k. Minimum latency 2 cycles (slave ready combinationally at T+1).
- Unmapped access: up_rdy at T+1.
- Timeout: counter clears on ACC entry and increments each ACC cycle. up_rdy at T+1+TOUT_MAX+1.
- up_rdy deasserts the cycle after up_cs is sampled low.

## Configuration
- UPBUS_TIMEOUT_EN defined: timeout counter and err_tout are implemented as above.
- UPBUS_TIMEOUT_EN undefined: ACC waits indefinitely for slv_rdy or abort. err_tout is tied 0 and TOUT_W/TOUT_MAX are unused.

## Structure
- Package upbus_pkg holds:
  - FSM state encoding (2-bit)
  - UPBUS_AW=25 and UPBUS_DW=16
  - RDD_UNMAPPED=16'hBAD0 and RDD_TIMEOUT=16'hDEAD
- Sub-module upbus_tout: clear/enable counter with a `expired` output. It is instantiated only under UPBUS_TIMEOUT_EN.

## Test plan
- Read slave 2: up_addr=25'h0200034, up_rds, slave 2 returns 16'h1234 with rdy 3 cycles later -> slv_sel=4'b0100, slv_addr=20'h00034, single slv_rds pulse, up_rdd=16'h1234, up_rdy until up_cs low.
- Write slave 0: up_addr=25'h0000010, up_wrd=16'hA5A5, rdy immediate -> slv_wrs[0] one cycle, slv_wrd=16'hA5A5, up_rdy at T+2, up_rdd unchanged.
- Unmapped read: up_addr=25'h1F00000 -> no slave strobe, up_rdd=16'hBAD0, up_rdy at T+1, err_dec=1; pulse err_clr -> err_dec=0.
- Timeout, UPBUS_TIMEOUT_EN defined, TOUT_MAX=255: read slave 1 with no rdy -> up_rdd=16'hDEAD, err_tout=1, up_rdy at T+257.
- Abort: up_cs drops 2 cycles into ACC -> IDLE, up_rdy never asserts, slv_sel=0. A subsequent read of slave 3 then completes normally.
- Async reset asserted in ACC -> all outputs 0 immediately. The next access after reset works.
